// File: rtl/qspim_host_if.sv
// Request/response and QSPI pad bundle for qspim_host; master = the QSPI host, slave = requester plus flash side.
interface qspim_host_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        busy;
  logic        spi_sck;
  logic        spi_csn;
  logic [3:0]  spi_so;
  logic        spi_oen;
  logic [3:0]  spi_si;

  modport master (
    input  req_valid, req_we, req_addr, req_wdata, spi_si,
    output req_ready, rsp_valid, rsp_rdata, busy, spi_sck, spi_csn, spi_so, spi_oen
  );

  modport slave (
    output req_valid, req_we, req_addr, req_wdata, spi_si,
    input  req_ready, rsp_valid, rsp_rdata, busy, spi_sck, spi_csn, spi_so, spi_oen
  );
endinterface

// File: rtl/qspim_host.sv
// Quad-SPI host: one request becomes a cmd/addr/[dummy]/data frame, SCK half-period CLK_DIV+1 cycles.
// Response pulses (2N+1)*H cycles after accept; req_ready stays low for the frame plus the CSN_IDLE gap.
module qspim_host #(
  parameter int unsigned CLK_DIV   = 1,
  parameter int unsigned DUMMY_CYC = 4,
  parameter logic [7:0]  CMD_WR    = 8'h02,
  parameter logic [7:0]  CMD_RD    = 8'h0B,
  parameter int unsigned CSN_IDLE  = 2
) (
  input logic          sys_clk,
  input logic          rst,
  qspim_host_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_WDATA, S_DUMMY, S_RDATA, S_HOLD, S_GAP
  } state_t;

  localparam logic [15:0] DIV_LAST   = 16'(CLK_DIV);
  localparam logic [7:0]  DUMMY_LAST = 8'((DUMMY_CYC > 0) ? DUMMY_CYC - 1 : 0);
  localparam logic [7:0]  GAP_LAST   = 8'((CSN_IDLE > 0) ? CSN_IDLE - 1 : 0);

  state_t      r_state, w_state;
  logic [15:0] r_div, w_div;
  logic [7:0]  r_cnt, w_cnt;
  logic        r_sck, w_sck;
  logic        r_csn, w_csn;
  logic        r_oen, w_oen;
  logic        r_we, w_we;
  logic        r_busy, w_busy;
  logic        r_rsp_vld, w_rsp_vld;
  logic [71:0] r_tx, w_tx;
  logic [31:0] r_rx, w_rx;
  logic [31:0] r_rdata, w_rdata;
  logic        w_tick, w_rise, w_fall;

  assign w_tick = (r_state != S_IDLE) && (r_div == DIV_LAST);
  assign w_rise = w_tick && !r_sck;
  assign w_fall = w_tick && r_sck;
  assign w_div  = ((r_state == S_IDLE) || w_tick) ? 16'd0 : r_div + 16'd1;

  always_comb begin
    w_state   = r_state;
    w_cnt     = r_cnt;
    w_sck     = r_sck;
    w_csn     = r_csn;
    w_oen     = r_oen;
    w_we      = r_we;
    w_busy    = r_busy;
    w_rsp_vld = 1'b0;
    w_tx      = r_tx;
    w_rx      = r_rx;
    w_rdata   = r_rdata;
    case (r_state)
      S_IDLE: begin
        if (bus.req_valid) begin
          w_state = S_CMD;
          w_cnt   = 8'd0;
          w_sck   = 1'b0;
          w_csn   = 1'b0;
          w_oen   = 1'b0;
          w_busy  = 1'b1;
          w_we    = bus.req_we;
          w_tx    = {bus.req_we ? CMD_WR : CMD_RD, bus.req_addr, bus.req_wdata};
        end
      end
      S_CMD, S_ADDR, S_WDATA, S_DUMMY, S_RDATA: begin
        if (w_rise) begin
          w_sck = 1'b1;
          if (r_state == S_RDATA) w_rx = {r_rx[27:0], bus.spi_si};
        end else if (w_fall) begin
          // Falling tick: launch the next nibble and close out one SCK cycle.
          w_sck = 1'b0;
          w_tx  = {r_tx[67:0], 4'h0};
          w_cnt = r_cnt + 8'd1;
          case (r_state)
            S_CMD: begin
              if (r_cnt == 8'd1) begin
                w_state = S_ADDR;
                w_cnt   = 8'd0;
              end
            end
            S_ADDR: begin
              if (r_cnt == 8'd7) begin
                w_cnt = 8'd0;
                if (r_we) begin
                  w_state = S_WDATA;
                end else begin
                  w_oen   = 1'b1;
                  w_state = (DUMMY_CYC == 0) ? S_RDATA : S_DUMMY;
                end
              end
            end
            S_DUMMY: begin
              if (r_cnt == DUMMY_LAST) begin
                w_state = S_RDATA;
                w_cnt   = 8'd0;
              end
            end
            S_WDATA, S_RDATA: begin
              if (r_cnt == 8'd7) begin
                w_state = S_HOLD;
                w_cnt   = 8'd0;
              end
            end
            default: ;
          endcase
        end
      end
      S_HOLD: begin
        if (w_tick) begin
          w_state   = S_GAP;
          w_csn     = 1'b1;
          w_oen     = 1'b1;
          w_rsp_vld = 1'b1;
          if (!r_we) w_rdata = r_rx;
        end
      end
      S_GAP: begin
        if (w_tick) begin
          if (r_cnt == GAP_LAST) begin
            w_state = S_IDLE;
            w_busy  = 1'b0;
          end else begin
            w_cnt = r_cnt + 8'd1;
          end
        end
      end
      default: w_state = S_GAP;
    endcase
  end

  // Reset lands in GAP so chip select is guaranteed its idle time before any frame.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_state   <= S_GAP;
      r_div     <= 16'd0;
      r_cnt     <= 8'd0;
      r_sck     <= 1'b0;
      r_csn     <= 1'b1;
      r_oen     <= 1'b1;
      r_we      <= 1'b0;
      r_busy    <= 1'b0;
      r_rsp_vld <= 1'b0;
      r_tx      <= '0;
      r_rx      <= '0;
      r_rdata   <= '0;
    end else begin
      r_state   <= w_state;
      r_div     <= w_div;
      r_cnt     <= w_cnt;
      r_sck     <= w_sck;
      r_csn     <= w_csn;
      r_oen     <= w_oen;
      r_we      <= w_we;
      r_busy    <= w_busy;
      r_rsp_vld <= w_rsp_vld;
      r_tx      <= w_tx;
      r_rx      <= w_rx;
      r_rdata   <= w_rdata;
    end
  end

  assign bus.req_ready = (r_state == S_IDLE);
  assign bus.rsp_valid = r_rsp_vld;
  assign bus.rsp_rdata = r_rdata;
  assign bus.busy      = r_busy;
  assign bus.spi_sck   = r_sck;
  assign bus.spi_csn   = r_csn;
  assign bus.spi_oen   = r_oen;
  assign bus.spi_so    = r_oen ? 4'h0 : r_tx[71:68];

endmodule

// File: tb/tb_qspim_host.sv
`timescale 1ns/1ps
// Bench for qspim_host: instance 0 divides SCK and uses dummy cycles, instance 1 runs SCK at full rate without them.
module tb_qspim_host;
  localparam int unsigned DIV0 = 1, DUM0 = 4, DIV1 = 0, DUM1 = 0, GAPN = 2;
  localparam logic [7:0] C_WR = 8'h02, C_RD = 8'h0B;

  logic sys_clk = 1'b0;
  logic rst = 1'b1;
  always #5 sys_clk = ~sys_clk;

  qspim_host_if if0 ();
  qspim_host_if if1 ();

  qspim_host #(.CLK_DIV(DIV0), .DUMMY_CYC(DUM0), .CMD_WR(C_WR), .CMD_RD(C_RD), .CSN_IDLE(GAPN))
    u_dut0 (.sys_clk(sys_clk), .rst(rst), .bus(if0));
  qspim_host #(.CLK_DIV(DIV1), .DUMMY_CYC(DUM1), .CMD_WR(C_WR), .CMD_RD(C_RD), .CSN_IDLE(GAPN))
    u_dut1 (.sys_clk(sys_clk), .rst(rst), .bus(if1));

  logic        tb_vld[2], tb_we[2];
  logic [31:0] tb_addr[2], tb_wdata[2];
  logic [3:0]  tb_si[2];
  logic        ob_rdy[2], ob_rsp[2], ob_busy[2], ob_sck[2], ob_csn[2], ob_oen[2];
  logic [31:0] ob_rdata[2];
  logic [3:0]  ob_so[2];

  assign if0.req_valid = tb_vld[0];   assign if1.req_valid = tb_vld[1];
  assign if0.req_we    = tb_we[0];    assign if1.req_we    = tb_we[1];
  assign if0.req_addr  = tb_addr[0];  assign if1.req_addr  = tb_addr[1];
  assign if0.req_wdata = tb_wdata[0]; assign if1.req_wdata = tb_wdata[1];
  assign if0.spi_si    = tb_si[0];    assign if1.spi_si    = tb_si[1];
  assign ob_rdy[0]   = if0.req_ready; assign ob_rdy[1]   = if1.req_ready;
  assign ob_rsp[0]   = if0.rsp_valid; assign ob_rsp[1]   = if1.rsp_valid;
  assign ob_rdata[0] = if0.rsp_rdata; assign ob_rdata[1] = if1.rsp_rdata;
  assign ob_busy[0]  = if0.busy;      assign ob_busy[1]  = if1.busy;
  assign ob_sck[0]   = if0.spi_sck;   assign ob_sck[1]   = if1.spi_sck;
  assign ob_csn[0]   = if0.spi_csn;   assign ob_csn[1]   = if1.spi_csn;
  assign ob_so[0]    = if0.spi_so;    assign ob_so[1]    = if1.spi_so;
  assign ob_oen[0]   = if0.spi_oen;   assign ob_oen[1]   = if1.spi_oen;

  function automatic int hp(input int u);
    return (u == 0) ? int'(DIV0) + 1 : int'(DIV1) + 1;
  endfunction
  function automatic int dum(input int u);
    return (u == 0) ? int'(DUM0) : int'(DUM1);
  endfunction

  // Pad-level observer plus flash read-data source, sampled mid-cycle.
  logic        prev_csn[2] = '{1'b1, 1'b1};
  logic        prev_sck[2] = '{1'b0, 1'b0};
  int          rise_cnt[2] = '{0, 0};
  int          csn_cyc[2]  = '{0, 0};
  int          csn_low[2]  = '{0, 0};
  int          gap_cyc[2]  = '{0, 0};
  int          last_gap[2] = '{0, 0};
  int          run_len[2]  = '{0, 0};
  int          max_run[2]  = '{0, 0};
  int          rsp_cnt[2]  = '{0, 0};
  logic [31:0] rsp_dat[2];
  logic [31:0] rd_model[2] = '{32'h0, 32'h0};
  logic [31:0] rd_hold[2]  = '{32'h0, 32'h0};
  logic [3:0]  so_log[2][32];
  logic        oen_log[2][32];

  always @(negedge sys_clk) begin : mon
    int idx;
    for (int u = 0; u < 2; u++) begin
      if (!ob_csn[u]) begin
        if (prev_csn[u]) begin
          rise_cnt[u] = 0; csn_cyc[u] = 0; run_len[u] = 0; max_run[u] = 0;
          last_gap[u] = gap_cyc[u];
        end
        csn_cyc[u]++;
        if (ob_sck[u] != prev_sck[u]) begin
          if (run_len[u] > max_run[u]) max_run[u] = run_len[u];
          run_len[u] = 1;
        end else begin
          run_len[u]++;
        end
        if (ob_sck[u] && !prev_sck[u]) begin
          if (rise_cnt[u] < 32) begin
            so_log[u][rise_cnt[u]]  = ob_so[u];
            oen_log[u][rise_cnt[u]] = ob_oen[u];
          end
          rise_cnt[u]++;
        end
      end else begin
        if (!prev_csn[u]) begin
          csn_low[u] = csn_cyc[u];
          gap_cyc[u] = 0;
        end
        gap_cyc[u]++;
      end
      if (ob_rsp[u]) begin
        rsp_cnt[u]++;
        rsp_dat[u] = ob_rdata[u];
      end
      prev_csn[u] = ob_csn[u];
      prev_sck[u] = ob_sck[u];
      idx = rise_cnt[u] - (10 + dum(u));
      if (!ob_csn[u] && idx >= 0 && idx < 8) tb_si[u] = rd_model[u][31 - 4*idx -: 4];
      else tb_si[u] = 4'($urandom);
    end
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge sys_clk);
    #1;
  endtask

  task automatic issue(input int u, input logic we, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] rd);
    int t = 0;
    rd_model[u] = rd;
    while (!ob_rdy[u] && t < 500) begin tick(); t++; end
    chk("ready_wait", 72'(t < 500), 72'(1));
    tb_vld[u] = 1'b1; tb_we[u] = we; tb_addr[u] = a; tb_wdata[u] = wd;
    tick();
    tb_vld[u] = 1'b0; tb_we[u] = 1'($urandom); tb_addr[u] = $urandom; tb_wdata[u] = $urandom;
  endtask

  task automatic wait_done(input int u, input int n0);
    int t = 0;
    while (!(rsp_cnt[u] > n0 && ob_rdy[u]) && t < 2000) begin tick(); t++; end
    chk("done_wait", 72'(t < 2000), 72'(1));
  endtask

  // Expected frame from the protocol rules: nibble stream, SCK count, CS width, release point.
  task automatic check_frame(input int u, input logic we, input logic [31:0] a,
                             input logic [31:0] wd, input logic [31:0] rd, input int n0);
    logic [71:0] ev, ov;
    logic [31:0] eo, oo;
    logic [3:0]  rest;
    int ncyc, nd;
    ncyc = 18 + (we ? 0 : dum(u));
    nd   = we ? 18 : 10;
    ev = {we ? C_WR : C_RD, a, wd};
    if (!we) ev[31:0] = '0;
    ov = '0; eo = '0; oo = '0; rest = '0;
    for (int i = 0; i < ncyc; i++) begin
      if (i < nd) ov[71 - 4*i -: 4] = so_log[u][i];
      else rest = rest | so_log[u][i];
      eo[i] = !we && (i >= 10);
      oo[i] = oen_log[u][i];
    end
    chk("sck_rises", 72'(rise_cnt[u]), 72'(ncyc));
    chk("csn_low_cycles", 72'(csn_low[u]), 72'((2*ncyc + 1) * hp(u)));
    chk("rsp_pulses", 72'(rsp_cnt[u]), 72'(n0 + 1));
    chk("so_nibbles", ov, ev);
    chk("so_released", 72'(rest), 72'(0));
    chk("oen_at_rises", 72'(oo), 72'(eo));
    chk("sck_half_period", 72'(max_run[u]), 72'(hp(u)));
    if (!we) begin
      rd_hold[u] = rd;
      chk("rsp_rdata_pulse", 72'(rsp_dat[u]), 72'(rd));
    end
    chk("rsp_rdata_held", 72'(ob_rdata[u]), 72'(rd_hold[u]));
    chk("idle_after_gap", 72'({ob_busy[u], ob_csn[u], ob_oen[u]}), 72'(3'b011));
  endtask

  task automatic do_txn(input int u, input logic we, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rd);
    int n0;
    n0 = rsp_cnt[u];
    issue(u, we, a, wd, rd);
    wait_done(u, n0);
    check_frame(u, we, a, wd, rd, n0);
  endtask

  initial begin
    int first[2];
    int n0, t, ph, viol;
    logic [31:0] a1, d1, a2, d2;
    for (int u = 0; u < 2; u++) begin
      tb_vld[u] = 1'b0; tb_we[u] = 1'b0; tb_addr[u] = '0; tb_wdata[u] = '0;
    end

    // Reset values, then req_ready only after the CS idle gap.
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_pads0", 72'({ob_csn[0], ob_sck[0], ob_oen[0], ob_so[0]}), 72'(7'b1010000));
    chk("rst_pads1", 72'({ob_csn[1], ob_sck[1], ob_oen[1], ob_so[1]}), 72'(7'b1010000));
    chk("rst_rsp0", 72'({ob_rsp[0], ob_busy[0], ob_rdy[0], ob_rdata[0]}), 72'(0));
    rst = 1'b0;
    first[0] = 0; first[1] = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      for (int u = 0; u < 2; u++) if (ob_rdy[u] && first[u] == 0) first[u] = k;
    end
    chk("ready_after_rst0", 72'(first[0]), 72'(GAPN * hp(0)));
    chk("ready_after_rst1", 72'(first[1]), 72'(GAPN * hp(1)));

    do_txn(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0);
    do_txn(0, 1'b0, 32'h0000_0004, 32'h0, 32'h1234_5678);

    // Two writes with req_valid held high; inputs swapped once frame 1 is underway.
    n0 = rsp_cnt[0];
    a1 = $urandom; d1 = $urandom; a2 = $urandom; d2 = $urandom;
    tb_vld[0] = 1'b1; tb_we[0] = 1'b1; tb_addr[0] = a1; tb_wdata[0] = d1;
    ph = 0; viol = 0; t = 0;
    while (!(ph == 3 && rsp_cnt[0] == n0 + 2 && ob_rdy[0]) && t < 1000) begin
      tick(); t++;
      if (ob_busy[0] && ob_rdy[0]) viol++;
      case (ph)
        0: if (ob_busy[0]) begin tb_addr[0] = a2; tb_wdata[0] = d2; ph = 1; end
        1: if (!ob_busy[0]) begin
             chk("b2b_frame1_rsp", 72'(rsp_cnt[0]), 72'(n0 + 1));
             chk("b2b_frame1_csn", 72'(csn_low[0]), 72'(37 * hp(0)));
             ph = 2;
           end
        2: if (ob_busy[0]) begin tb_vld[0] = 1'b0; ph = 3; end
        default: ;
      endcase
    end
    chk("b2b_wait", 72'(t < 1000), 72'(1));
    chk("b2b_ready_in_frame", 72'(viol), 72'(0));
    chk("b2b_csn_gap", 72'(last_gap[0] >= GAPN * hp(0)), 72'(1));
    check_frame(0, 1'b1, a2, d2, 32'h0, n0 + 1);

    // Reset in the middle of the address phase.
    n0 = rsp_cnt[0];
    issue(0, 1'b0, $urandom, 32'h0, $urandom);
    t = 0;
    while (rise_cnt[0] < 5 && t < 500) begin tick(); t++; end
    chk("addr_reach", 72'(t < 500), 72'(1));
    rst = 1'b1;
    tick();
    chk("midrst_pads", 72'({ob_csn[0], ob_sck[0], ob_oen[0]}), 72'(3'b101));
    rst = 1'b0;
    rd_hold[0] = '0; rd_hold[1] = '0;
    t = 0;
    while (!ob_rdy[0] && t < 500) begin tick(); t++; end
    chk("midrst_no_rsp", 72'(rsp_cnt[0]), 72'(n0));
    chk("midrst_rdata", 72'(ob_rdata[0]), 72'(0));
    do_txn(0, 1'b0, $urandom, 32'h0, $urandom);

    // Full-rate SCK, no dummy cycles.
    do_txn(1, 1'b0, $urandom, 32'h0, 32'hA5A5_5A5A);
    do_txn(1, 1'b1, $urandom, $urandom, 32'h0);

    for (int n = 0; n < 6; n++) begin
      do_txn(n % 2, 1'($urandom), $urandom, $urandom, $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
